// File: rtl/arb_requester_if.sv
// arb_requester_if: job and arbiter handshake bundle for one requester port.
//   start, len, base_prio : job strobe, owned length, static priority
//   grant                 : arbiter grant for this port
//   req, prio             : request and priority toward the arbiter
//   busy, done, abort     : requester status
// The slave modport is the requester side; the master modport is the job
// source / arbiter side.
interface arb_requester_if #(
  parameter int LEN_W = 4
);
  logic             start;
  logic [LEN_W-1:0] len;
  logic [1:0]       base_prio;
  logic             grant;
  logic             req;
  logic [1:0]       prio;
  logic             busy;
  logic             done;
  logic             abort;

  modport master (
    output start, len, base_prio, grant,
    input  req, prio, busy, done, abort
  );

  modport slave (
    input  start, len, base_prio, grant,
    output req, prio, busy, done, abort
  );
endinterface

// File: rtl/arb_requester.sv
// arb_requester: upstream requester agent for one port of the two-way arbiter.
// Takes a job (start + len), requests the arbiter, owns the grant for exactly
// len cycles, then drops req for one RELEASE cycle and pulses done (or abort
// if the grant was lost early). All outputs are registered.
//
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : arb_requester_if.slave (start/len/base_prio/grant in,
//          req/prio/busy/done/abort out)
//
// Optional feature macro: PRIO_AGING_EN -- while waiting in REQ, prio steps up
// by one every AGE_CYCLES cycles, saturating at 3, and keeps the aged value
// through OWN.
//
// state   | meaning
// IDLE    | no job, req=0, accepts start
// REQ     | requesting, waiting for grant
// OWN     | grant held, length counter running
// RELEASE | one cycle with req=0, done/abort pulse
module arb_requester #(
  parameter int LEN_W      = 4,
  parameter int AGE_CYCLES = 4
) (
  input logic            clk,
  input logic            rst,
  arb_requester_if.slave bus
);

  if (AGE_CYCLES < 1) begin : g_bad_age
    $error("AGE_CYCLES must be at least 1");
  end

  typedef enum logic [1:0] {IDLE, REQ, OWN, RELEASE} state_t;

  state_t           state;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] len_cnt;

`ifdef PRIO_AGING_EN
  localparam int AGE_W = $clog2(AGE_CYCLES + 1);
  localparam logic [AGE_W-1:0] AGE_LAST = AGE_W'(AGE_CYCLES - 1);
  logic [AGE_W-1:0] wait_cnt;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      len_q     <= '0;
      len_cnt   <= '0;
      bus.req   <= 1'b0;
      bus.prio  <= 2'd0;
      bus.busy  <= 1'b0;
      bus.done  <= 1'b0;
      bus.abort <= 1'b0;
`ifdef PRIO_AGING_EN
      wait_cnt  <= '0;
`endif
    end else begin
      bus.done  <= 1'b0;
      bus.abort <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            bus.busy <= 1'b1;
            if (bus.len != '0) begin
              state    <= REQ;
              len_q    <= bus.len;
              bus.req  <= 1'b1;
              bus.prio <= bus.base_prio;
`ifdef PRIO_AGING_EN
              wait_cnt <= '0;
`endif
            end else begin
              // empty job: complete without ever requesting
              state    <= RELEASE;
              bus.done <= 1'b1;
            end
          end
        end

        REQ: begin
          if (bus.grant) begin
            state   <= OWN;
            len_cnt <= len_q;
`ifdef PRIO_AGING_EN
            wait_cnt <= '0;
`endif
          end
`ifdef PRIO_AGING_EN
          else if (bus.prio != 2'd3) begin
            // counter only runs while prio can still rise, so it never wraps
            if (wait_cnt == AGE_LAST) begin
              wait_cnt <= '0;
              bus.prio <= bus.prio + 2'd1;
            end else begin
              wait_cnt <= wait_cnt + 1'b1;
            end
          end
`endif
        end

        OWN: begin
          // expiry wins over a simultaneous grant drop
          if (len_cnt == LEN_W'(1)) begin
            state    <= RELEASE;
            bus.req  <= 1'b0;
            bus.prio <= 2'd0;
            bus.done <= 1'b1;
          end else if (!bus.grant) begin
            state     <= RELEASE;
            bus.req   <= 1'b0;
            bus.prio  <= 2'd0;
            bus.abort <= 1'b1;
          end else begin
            len_cnt <= len_cnt - 1'b1;
          end
        end

        RELEASE: begin
          state    <= IDLE;
          bus.busy <= 1'b0;
        end

        default: begin
          state    <= IDLE;
          bus.req  <= 1'b0;
          bus.prio <= 2'd0;
          bus.busy <= 1'b0;
        end
      endcase
    end
  end

endmodule
